proc_control_unit: RTL
======================

Name: proc_control_unit

Overview:
Multi-cycle control FSM of the down-sampling processor. It sequences fetch, decode and execute for every instruction. It drives the instruction-register load strobe (inst_en), program-counter controls, memory strobes and datapath selects. It consumes the Op_code / reg_add1 / reg_add2 fields captured by the instruction register.

Parameters:
MEM_LAT, 2, memory read/write latency in cycles (legal range 1..15).
CNT_W, 4, width of the internal latency counter.

Ports:
clk  input  1  system clock; FSM updates on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin execution from IDLE (level, sampled in IDLE only).
Op_code  input  4  opcode from the instruction register.
reg_add1  input  1  register bank/select bit from the instruction register.
reg_add2  input  3  register index from the instruction register.
z_flag  input  1  accumulator-zero flag from the ALU.
inst_en  output  1  one-cycle strobe; the instruction register captures on the following negedge.
pc_inc  output  1  PC += 1 this cycle.
pc_load  output  1  PC <= data bus this cycle.
addr_sel  output  1  memory address source: 0 = PC, 1 = AR.
mem_rd  output  1  memory read strobe.
mem_wr  output  1  memory write strobe.
alu_op  output  3  0 = pass, 1 = add, 2 = sub, 3 = inc, 4 = shr1, 5 = shr2.
ac_load  output  1  accumulator write enable.
reg_wr  output  1  register-file write enable.
reg_sel  output  4  {reg_add1, reg_add2} latched in DECODE.
busy  output  1  high in every state except IDLE and HALT.
halted  output  1  high in HALT.
illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset values: all strobes 0, alu_op = 0, reg_sel = 0, addr_sel = 0, illegal = 0, busy = 0, halted = 0. State = IDLE, latency counter = 0.
- Reset applies in any state, mid-instruction included. No strobe is asserted in the cycle after rst.
- Outputs are Moore: decoded from the state register only. reg_sel is a register.
- Opcode map:
  - 0 NOP
  - 1 LDAC (AC <= M[AR])
  - 2 STAC (M[AR] <= AC)
  - 3 MVAC (R <= AC)
  - 4 MOVR (AC <= R)
  - 5 ADD
  - 6 SUB
  - 7 INAC
  - 8 SHR1
  - 9 SHR2
  - A JUMP
  - B JMPZ
  - C JPNZ
  - F HALT
  - D and E are illegal.
- State IDLE: start = 1 -> FETCH.
- State FETCH: addr_sel = 0, mem_rd = 1 for MEM_LAT cycles (counter), then -> LATCH.
- State LATCH: inst_en = 1, pc_inc = 1 for exactly one cycle -> DECODE.
- State DECODE: latch reg_sel, then branch on Op_code:
  - NOP -> FETCH.
  - ALU ops 5-9 -> EXEC.
  - MVAC / MOVR -> EXEC.
  - LDAC -> MRD.
  - STAC -> MWR.
  - JUMP -> JFETCH.
  - JMPZ with z_flag = 1, or JPNZ with z_flag = 0 -> JFETCH; otherwise -> SKIP.
  - HALT -> HALT.
- State EXEC: one cycle, then -> FETCH.
  - ALU ops: alu_op set, ac_load = 1.
  - MOVR: alu_op = pass, ac_load = 1.
  - MVAC: reg_wr = 1.
- State MRD: addr_sel = 1, mem_rd = 1 for MEM_LAT cycles -> WB.
- State WB: ac_load = 1, alu_op = pass -> FETCH.
- State MWR: addr_sel = 1, mem_wr = 1 for MEM_LAT cycles -> FETCH.
- State JFETCH: addr_sel = 0, mem_rd = 1 for MEM_LAT cycles -> JLOAD.
- State JLOAD: pc_load = 1 -> FETCH.
- State SKIP: pc_inc = 1 for one cycle (steps over the operand byte) -> FETCH.
- State HALT: halted = 1; stays until rst. start is ignored.
- Latency counter: loads MEM_LAT-1 on entry to any memory state and exits at 0. MEM_LAT = 1 gives single-cycle strobes.
- Instruction latencies:
  - NOP: MEM_LAT + 2 cycles.
  - ALU and move ops: MEM_LAT + 3.
  - LDAC: 2·MEM_LAT + 3.
  - Taken jump: 2·MEM_LAT + 3.
- z_flag is sampled only in DECODE.
- Only one of mem_rd / mem_wr / ac_load / reg_wr / pc_load / pc_inc combinations listed above is ever active in a cycle.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: opcodes D/E set illegal = 1 (sticky until rst) and go DECODE -> HALT.
- Undefined: D/E behave as NOP and illegal is tied 0.

Decomposition:
- Package proc_cu_pkg holds:
  - the opcode localparams (OP_NOP .. OP_HALT);
  - the state encoding (IDLE, FETCH, LATCH, DECODE, EXEC, MRD, WB, MWR, JFETCH, JLOAD, SKIP, HALT);
  - the ALU_OP codes.
- One natural sub-module, proc_cu_lat_ctr: the load/decrement latency counter with a done output.

Test Plan:
- rst held 3 cycles mid-MRD -> all strobes 0 next cycle, state IDLE, busy = 0; start = 1 then restarts at FETCH.
- MEM_LAT = 2, start, Op_code = 5 (ADD) -> mem_rd high 2 cycles, inst_en/pc_inc 1 cycle, then alu_op = 1 with ac_load = 1 exactly one cycle; 5 cycles FETCH-to-FETCH.
- Op_code = 1 (LDAC), MEM_LAT = 3 -> addr_sel = 1 with mem_rd for 3 cycles, then ac_load = 1 one cycle, alu_op = 0.
- Op_code = B, z_flag = 0 -> SKIP: single pc_inc, no pc_load. With z_flag = 1 -> mem_rd 2 cycles, then pc_load = 1.
- Op_code = 3, reg_add1 = 1, reg_add2 = 5 -> reg_sel = 4'hD, reg_wr = 1 one cycle.
- Op_code = F -> halted = 1, busy = 0; start pulses ignored. Op_code = D with ILLEGAL_TRAP_EN -> illegal = 1 and halted = 1; without the macro it behaves as NOP with illegal = 0.

Source files
------------

// File: rtl/proc_cu_pkg.sv
// Shared definitions for the down-sampling processor control unit:
// opcodes, FSM state encoding and ALU operation codes.
package proc_cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_INAC = 4'h7;
  localparam logic [3:0] OP_SHR1 = 4'h8;
  localparam logic [3:0] OP_SHR2 = 4'h9;
  localparam logic [3:0] OP_JUMP = 4'hA;
  localparam logic [3:0] OP_JMPZ = 4'hB;
  localparam logic [3:0] OP_JPNZ = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_INC  = 3'd3;
  localparam logic [2:0] ALU_SHR1 = 3'd4;
  localparam logic [2:0] ALU_SHR2 = 3'd5;

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, DECODE, EXEC, MRD, WB, MWR, JFETCH, JLOAD, SKIP, HALT
  } state_t;

  // States that hold a memory strobe for MEM_LAT cycles
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MRD) || (s == MWR) || (s == JFETCH);
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_INAC: return ALU_INC;
      OP_SHR1: return ALU_SHR1;
      OP_SHR2: return ALU_SHR2;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/proc_cu_lat_ctr.sv
// Memory latency counter: loads LOAD_VAL, counts down to zero and holds;
// done is high while the count is zero.
module proc_cu_lat_ctr #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(LOAD_VAL);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute control FSM of the down-sampling processor.
// Optional macro ILLEGAL_TRAP_EN: opcodes D/E set sticky illegal and halt.
module proc_control_unit
  import proc_cu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] Op_code,
  input  logic       reg_add1,
  input  logic [2:0] reg_add2,
  input  logic       z_flag,
  output logic       inst_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] alu_op,
  output logic       ac_load,
  output logic       reg_wr,
  output logic [3:0] reg_sel,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  state_t     state, nxt;
  logic [3:0] op_q;
  logic       lat_done;
  logic       lat_load;

  // Counter is loaded on the edge that enters a memory state
  assign lat_load = is_mem_state(nxt) && (nxt != state);

  proc_cu_lat_ctr #(.CNT_W(CNT_W), .LOAD_VAL(MEM_LAT - 1)) u_lat_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load),
    .done (lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      reg_sel <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) begin
        op_q    <= Op_code;
        reg_sel <= {reg_add1, reg_add2};
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (rst)
      ill_q <= 1'b0;
    else if (state == DECODE && (Op_code == 4'hD || Op_code == 4'hE))
      ill_q <= 1'b1;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (start) nxt = FETCH;
      FETCH:  if (lat_done) nxt = LATCH;
      LATCH:  nxt = DECODE;
      DECODE: begin
        case (Op_code)
          OP_NOP:  nxt = FETCH;
          OP_LDAC: nxt = MRD;
          OP_STAC: nxt = MWR;
          OP_MVAC, OP_MOVR, OP_ADD, OP_SUB, OP_INAC, OP_SHR1, OP_SHR2:
                   nxt = EXEC;
          OP_JUMP: nxt = JFETCH;
          OP_JMPZ: nxt = z_flag ? JFETCH : SKIP;
          OP_JPNZ: nxt = z_flag ? SKIP : JFETCH;
          OP_HALT: nxt = HALT;
`ifdef ILLEGAL_TRAP_EN
          default: nxt = HALT;
`else
          default: nxt = FETCH;
`endif
        endcase
      end
      EXEC:   nxt = FETCH;
      MRD:    if (lat_done) nxt = WB;
      WB:     nxt = FETCH;
      MWR:    if (lat_done) nxt = FETCH;
      JFETCH: if (lat_done) nxt = JLOAD;
      JLOAD:  nxt = FETCH;
      SKIP:   nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_en  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = ALU_PASS;
    ac_load  = 1'b0;
    reg_wr   = 1'b0;
    halted   = 1'b0;
    busy     = (state != IDLE) && (state != HALT);
    case (state)
      FETCH, JFETCH: mem_rd = 1'b1;
      LATCH: begin
        inst_en = 1'b1;
        pc_inc  = 1'b1;
      end
      EXEC: begin
        if (op_q == OP_MVAC) begin
          reg_wr = 1'b1;
        end else begin
          alu_op  = alu_code(op_q);
          ac_load = 1'b1;
        end
      end
      MRD: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
      end
      WB:    ac_load = 1'b1;
      MWR: begin
        addr_sel = 1'b1;
        mem_wr   = 1'b1;
      end
      JLOAD: pc_load = 1'b1;
      SKIP:  pc_inc = 1'b1;
      HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
